data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's data-memory request interface: accepts load/store requests from the CPU (MEM stage or a future cache/stall-capable MEM stage) over a valid/ready handshake.
- Services each request after a fixed, configurable latency and returns the result over a valid/ready response channel.
- Holds the word-addressed data RAM, with a combinational debug read port for the end-of-simulation memory dump.
- Models a realistic multi-cycle memory in place of the single-cycle main memory.

Parameters:
- DEPTH_WORDS, 512, number of 32-bit words (512 = 2048 bytes); must be a power of two.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request was rejected (out of range, or misaligned when the optional feature is enabled).
- dbg_addr  input  log2(DEPTH_WORDS)  word index for the dump port.
- dbg_rdata  output  32  combinational RAM[dbg_addr].

Behaviour:
- Reset (async, any time):
  - state=IDLE, latency counter=0, resp_valid=0, resp_rdata=0, resp_err=0, captured request fields=0.
  - RAM contents are not cleared.
  - A request in WAIT is dropped. Its store is not committed unless the commit edge has already occurred.
- States: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE (combinational from state). The responder has one outstanding request at a time, with no pipelining.
- IDLE:
  - On a posedge with req_valid & req_ready, capture we/addr/wdata.
  - If LATENCY=1, perform the access on this edge and go to RESP.
  - Otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter equals 1, perform the access and go to RESP.
  - Result: resp_valid rises exactly LATENCY cycles after the acceptance edge.
- Access:
  - Word index = addr[2 +: log2(DEPTH_WORDS)].
  - Out of range (addr >= DEPTH_WORDS*4): store suppressed, resp_rdata=0, resp_err=1.
  - Store: RAM[index] <= wdata, resp_rdata=0, resp_err=0.
  - Load: resp_rdata <= RAM[index], resp_err=0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable while resp_valid & !resp_ready.
  - On a posedge with resp_ready, clear resp_valid, resp_rdata and resp_err and go to IDLE.
  - A new request cannot be accepted on the same edge as the response handshake, so the minimum request-to-request spacing is LATENCY+1 cycles.
- Inputs outside the handshake:
  - req_* changes while not in IDLE are ignored.
  - resp_ready is ignored outside RESP.
- dbg_rdata is purely combinational, independent of state, and reflects a store on the cycle after its commit edge.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- Defined: req_addr[1:0] != 0 is treated as misaligned. The store is suppressed, resp_rdata=0, resp_err=1, and timing is unchanged (still LATENCY cycles).
- Not defined: req_addr[1:0] is ignored, and the access goes to the enclosing word with no error.

Test Plan:
- LATENCY=2, store addr 0x10 data 0xDEADBEEF, then load 0x10 with resp_ready tied to 1 -> both responses have resp_valid exactly 2 cycles after acceptance; load resp_rdata=0xDEADBEEF, resp_err=0; dbg_addr=4 reads 0xDEADBEEF.
- Back-to-back: req_valid held high with 3 loads -> req_ready low from acceptance until after each response handshake; accepts spaced LATENCY+1=3 cycles.
- Response stall: load, resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable, req_ready stays 0; raising resp_ready returns the block to IDLE next edge.
- Out of range: store to 0x800 data 0x12345678 -> resp_err=1, resp_rdata=0; a load from 0x0 shows the prior value, with no wrap-around alias.
- Misaligned store to 0x13 data 0xAA:
  - with DATA_MEM_ALIGN_CHECK_EN -> resp_err=1, word 4 unchanged;
  - without -> resp_err=0, word 4 = 0xAA.
- RESET asserted mid-WAIT of a store (LATENCY=3, reset 1 cycle after accept) -> resp_valid=0 and req_ready=1 immediately; target word keeps its old value.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data-memory request interface. One
//   request is accepted at a time over a valid/ready handshake and serviced
//   after a fixed LATENCY. The result comes back over a valid/ready response
//   channel. The word-addressed data RAM is held here. A combinational debug
//   read port serves the end-of-simulation memory dump.
//
//   Parameters:
//     DEPTH_WORDS : number of 32-bit words (power of two)
//     LATENCY     : cycles from acceptance to resp_valid, 1..15
//
//   Ports:
//     CLK, RESET           : clock, asynchronous active-high reset
//     req_valid/req_ready  : request handshake (ready only when idle)
//     req_we               : 1 = store, 0 = load
//     req_addr, req_wdata  : byte address and store data
//     resp_valid/resp_ready: response handshake
//     resp_rdata, resp_err : load data (0 for stores/errors) and reject flag
//     dbg_addr, dbg_rdata  : combinational RAM read for memory dumps
//
//   Optional feature macro: DATA_MEM_ALIGN_CHECK_EN
//     When defined, a request with req_addr[1:0] != 0 is rejected with
//     resp_err=1 and its store is suppressed. When undefined, the low
//     address bits are ignored.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [31:0]                    req_addr,
  input  logic [31:0]                    req_wdata,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_rdata,
  output logic                           resp_err,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  output logic [31:0]                    dbg_rdata
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Access operands. With LATENCY=1 the access happens on the acceptance
  // edge, so the live request fields are used. Otherwise the captured ones are.
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_oor;
  logic          acc_misaligned;
  logic          acc_err;
  logic          do_access;
  logic          mem_we;

  always_comb begin
    acc_we    = (state_q == IDLE) ? req_we    : we_q;
    acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  end

  assign acc_idx = acc_addr[2 +: AW];
  // Any address bit above the RAM's byte range means out of range. There is
  // no aliasing back into the array.
  assign acc_oor = |acc_addr[31:AW+2];

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign acc_misaligned = (acc_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^acc_addr[1:0];
  assign acc_misaligned   = 1'b0;
`endif

  assign acc_err = acc_oor | acc_misaligned;

  assign do_access = ((state_q == IDLE) && req_valid && (LATENCY == 1)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1));

  // RESET gates the write so that an access edge coinciding with reset
  // never commits.
  assign mem_we = do_access && acc_we && !acc_err && !RESET;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_access) begin
      resp_valid_d = 1'b1;
      resp_err_d   = acc_err;
      resp_rdata_d = (!acc_we && !acc_err) ? mem[acc_idx] : 32'h0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dbg_rdata  = mem[dbg_addr];

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder.
// It uses two instances that share one clock:
//   u_dut  : 512 words, LATENCY=2. It runs the vector table, the
//            back-to-back sequence and the randomized phase against a
//            reference model.
//   u_dut3 : 16 words, LATENCY=3. It runs the reset-during-WAIT sequence.
// Latency is counted in clock edges, with the acceptance edge as edge 1.
// It is the edge after which resp_valid is first seen high.
module tb_data_mem_responder;

  localparam int DEPTH  = 512;
  localparam int LAT    = 2;
  localparam int DEPTH3 = 16;
  localparam int LAT3   = 3;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  // Word 4 after a misaligned store of 0xAA to 0x13 (word 4 held 0xDEADBEEF)
  localparam logic [31:0] MIS_LOAD = ALIGN ? 32'hDEADBEEF : 32'h000000AA;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata, dbg_rdata;
  logic [8:0]  dbg_addr;

  logic        rst3, d3_req_valid, d3_req_ready, d3_req_we, d3_resp_valid, d3_resp_ready, d3_resp_err;
  logic [31:0] d3_req_addr, d3_req_wdata, d3_resp_rdata, d3_dbg_rdata;
  logic [3:0]  d3_dbg_addr;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .CLK(CLK), .RESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH3), .LATENCY(LAT3)) u_dut3 (
    .CLK(CLK), .RESET(rst3),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_we(d3_req_we),
    .req_addr(d3_req_addr), .req_wdata(d3_req_wdata),
    .resp_valid(d3_resp_valid), .resp_ready(d3_resp_ready),
    .resp_rdata(d3_resp_rdata), .resp_err(d3_resp_err),
    .dbg_addr(d3_dbg_addr), .dbg_rdata(d3_dbg_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: a plain word array plus a written flag per word.
  logic [31:0] model_mem [DEPTH];
  bit          known     [DEPTH];

  task automatic model_step(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] exp_rdata, output logic exp_err, output bit rd_known);
    exp_err   = (addr >= 32'(DEPTH * 4)) || (ALIGN && (addr % 4 != 0));
    exp_rdata = 32'h0;
    rd_known  = 1'b1;
    if (!exp_err) begin
      if (we) begin
        model_mem[addr / 4] = wdata;
        known[addr / 4]     = 1'b1;
      end else begin
        rd_known  = known[addr / 4];
        exp_rdata = model_mem[addr / 4];
      end
    end
  endtask

  // One full transaction on u_dut. It is entered and left 1 time unit after
  // a posedge. resp_ready is randomized while waiting, which must be ignored.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int stall, output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge CLK); #1; guard++;
    end
    chk("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge CLK); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    resp_ready = 1'($urandom);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge CLK); #1; lat++;
    end
    chk("resp_wait", {31'b0, resp_valid}, 32'd1);
    resp_ready = 1'b0;
    rdata = resp_rdata;
    err   = resp_err;
    for (int s = 0; s < stall; s++) begin
      @(posedge CLK); #1;
      chk("stall_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, rdata);
      chk("stall_err", {31'b0, resp_err}, {31'b0, err});
      chk("stall_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    chk("hs_valid_clr", {31'b0, resp_valid}, 32'd0);
    chk("hs_idle", {31'b0, req_ready}, 32'd1);
    chk("hs_rdata_clr", resp_rdata, 32'h0);
    chk("hs_err_clr", {31'b0, resp_err}, 32'd0);
    $display("txn %0d we=%0d addr=0x%08h wdata=0x%08h stall=%0d -> rdata=0x%08h err=%0d lat=%0d",
             n_txn, we, addr, wdata, stall, rdata, err, lat);
    n_txn++;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rdata, exp_rdata, addr, wdata;
    logic        err, exp_err, we;
    bit          rd_known;
    int          lat, n_acc, n_rsp, sel, w;
    int          acc_cyc [3];

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0800, 32'h1234_5678, 0, 32'h0,         1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         2, 32'h1111_1111, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0800, 32'h0,         0, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h0000_07FC, 32'hCAFE_F00D, 0, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h0000_07FC, 32'h0,         3, 32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         0, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0013, 32'h0000_00AA, 0, 32'h0,         ALIGN};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,         0, MIS_LOAD,      1'b0};

    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 32'h0;
      known[i]     = 1'b0;
    end

    rst = 1'b1; rst3 = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0; dbg_addr = '0;
    d3_req_valid = 1'b0; d3_req_we = 1'b0; d3_req_addr = '0; d3_req_wdata = '0; d3_resp_ready = 1'b0; d3_dbg_addr = '0;
    repeat (3) @(posedge CLK);
    #1;
    rst = 1'b0; rst3 = 1'b0;
    @(posedge CLK); #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stall, rdata, err, lat);
      model_step(vecs[i].we, vecs[i].addr, vecs[i].wdata, exp_rdata, exp_err, rd_known);
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, LAT);
      if (i == 0) begin
        dbg_addr = 9'd4; #1;
        chk("dbg_word4_after_store", dbg_rdata, 32'hDEAD_BEEF);
      end
    end
    dbg_addr = 9'd4;   #1; chk("dbg_word4", dbg_rdata, MIS_LOAD);
    dbg_addr = 9'd0;   #1; chk("dbg_word0", dbg_rdata, 32'h1111_1111);
    dbg_addr = 9'd511; #1; chk("dbg_word511", dbg_rdata, 32'hCAFE_F00D);

    // Back-to-back loads with req_valid held high and resp_ready tied high
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; resp_ready = 1'b1;
    n_acc = 0; n_rsp = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    for (int c = 0; c < 30 && n_rsp < 3; c++) begin
      if (n_acc == 3) req_valid = 1'b0;
      if (req_ready && req_valid) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (resp_valid) begin
        chk("b2b_rdata", resp_rdata, MIS_LOAD);
        chk("b2b_ready_low", {31'b0, req_ready}, 32'd0);
        n_rsp++;
      end
      @(posedge CLK); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("b2b_responses", n_rsp, 3);
    chk("b2b_spacing01", acc_cyc[1] - acc_cyc[0], LAT + 1);
    chk("b2b_spacing12", acc_cyc[2] - acc_cyc[1], LAT + 1);
    $display("b2b accepts at cycles %0d %0d %0d", acc_cyc[0], acc_cyc[1], acc_cyc[2]);

    // Randomized phase: initialize a 16-word window, then random traffic
    for (int i = 0; i < 16; i++) begin
      addr = 32'(i * 4); wdata = $urandom;
      txn(1'b1, addr, wdata, 0, rdata, err, lat);
      model_step(1'b1, addr, wdata, exp_rdata, exp_err, rd_known);
      chk("init_err", {31'b0, err}, 32'd0);
    end
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 9);
      w   = $urandom_range(0, 15);
      if (sel < 7)      addr = 32'(w * 4);
      else if (sel < 8) addr = $urandom | 32'h0000_0800;
      else              addr = 32'(w * 4 + $urandom_range(1, 3));
      we    = 1'($urandom);
      wdata = $urandom;
      txn(we, addr, wdata, $urandom_range(0, 3), rdata, err, lat);
      model_step(we, addr, wdata, exp_rdata, exp_err, rd_known);
      chk("rnd_err", {31'b0, err}, {31'b0, exp_err});
      chk("rnd_lat", lat, LAT);
      if (rd_known) chk("rnd_rdata", rdata, exp_rdata);
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 9'(i); #1;
      chk($sformatf("rnd_dbg_word%0d", i), dbg_rdata, model_mem[i]);
    end

    // Reset during WAIT of a store on the LATENCY=3 instance
    d3_req_valid = 1'b1; d3_req_we = 1'b1; d3_req_addr = 32'h8; d3_req_wdata = 32'h5555_AAAA;
    @(posedge CLK); #1;
    d3_req_valid = 1'b0;
    lat = 1;
    while (!d3_resp_valid && lat < 40) begin
      @(posedge CLK); #1; lat++;
    end
    chk("d3_store_lat", lat, LAT3);
    d3_resp_ready = 1'b1;
    @(posedge CLK); #1;
    d3_resp_ready = 1'b0;
    d3_dbg_addr = 4'd2; #1;
    chk("d3_dbg_before", d3_dbg_rdata, 32'h5555_AAAA);

    d3_req_valid = 1'b1; d3_req_we = 1'b1; d3_req_addr = 32'h8; d3_req_wdata = 32'hBAD0_BAD0;
    @(posedge CLK); #1;
    d3_req_valid = 1'b0;
    chk("d3_wait_not_ready", {31'b0, d3_req_ready}, 32'd0);
    @(posedge CLK); #1;
    rst3 = 1'b1; #1;
    chk("d3_rst_valid", {31'b0, d3_resp_valid}, 32'd0);
    chk("d3_rst_ready", {31'b0, d3_req_ready}, 32'd1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    rst3 = 1'b0;
    @(posedge CLK); #1;
    chk("d3_dbg_after_rst", d3_dbg_rdata, 32'h5555_AAAA);
    chk("d3_post_valid", {31'b0, d3_resp_valid}, 32'd0);
    chk("d3_post_err", {31'b0, d3_resp_err}, 32'd0);

    d3_req_valid = 1'b1; d3_req_we = 1'b0; d3_req_addr = 32'h8;
    @(posedge CLK); #1;
    d3_req_valid = 1'b0;
    lat = 1;
    while (!d3_resp_valid && lat < 40) begin
      @(posedge CLK); #1; lat++;
    end
    chk("d3_load_lat", lat, LAT3);
    chk("d3_load_rdata", d3_resp_rdata, 32'h5555_AAAA);
    d3_resp_ready = 1'b1;
    @(posedge CLK); #1;
    d3_resp_ready = 1'b0;
    chk("d3_load_done", {31'b0, d3_req_ready}, 32'd1);
    $display("reset-in-WAIT sequence on LATENCY=3 instance complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
